mem_port_arbiter: RTL

- Shares the single access port of one MemUnit instance between two requesters: A is the load/store stage and B is the loader/debug path.
- Arbitration is round-robin with a bounded burst: the current owner may keep the port for up to BURST_MAX consecutive grants while the other requester waits.
- Read data is registered, so the response arrives one cycle after the grant.
- Sits between the pipeline's memory stage and MemUnit's _we/_vptr/_sw_data/lw_data_ port.

---
 rtl/mem_port_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single MemUnit access port: round-robin with a
// bounded burst for the current owner, registered read responses per requester.
module mem_port_arbiter #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic        _clk,
  input  logic        _reset,
  input  logic        _a_req,
  input  logic        _a_we,
  input  logic [31:0] _a_vptr,
  input  logic [31:0] _a_sw_data,
  output logic        a_gnt_,
  output logic        a_rsp_valid_,
  output logic [31:0] a_lw_data_,
  input  logic        _b_req,
  input  logic        _b_we,
  input  logic [31:0] _b_vptr,
  input  logic [31:0] _b_sw_data,
  output logic        b_gnt_,
  output logic        b_rsp_valid_,
  output logic [31:0] b_lw_data_,
  output logic        mem_we_,
  output logic [31:0] mem_vptr_,
  output logic [31:0] mem_sw_data_,
  input  logic [31:0] _mem_lw_data,
  input  logic        _en_trace
);

  // state | meaning
  // OWN_A | load/store stage holds the port (or held it last)
  // OWN_B | loader/debug path holds the port (or held it last)
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_t;

  localparam logic [3:0] BURST_LIM = 4'(BURST_MAX);

  owner_t      owner;
  logic [3:0]  burst_cnt;
  logic        rsp_valid_a, rsp_valid_b;
  logic [31:0] rsp_data_a, rsp_data_b;
  logic        grant_a, grant_b;
  logic        owner_wins;

  // Grant logging is a simulation-only activity; the hardware ignores the enable.
  logic unused_en_trace;
  assign unused_en_trace = _en_trace;

  assign owner_wins = (burst_cnt < BURST_LIM);

  // Grants are forced low while reset is high so no write can slip through.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!_reset) begin
      if (_a_req && !_b_req) begin
        grant_a = 1'b1;
      end else if (_b_req && !_a_req) begin
        grant_b = 1'b1;
      end else if (_a_req && _b_req) begin
        grant_a = ((owner == OWN_A) == owner_wins);
        grant_b = !grant_a;
      end
    end
  end

  always_comb begin
    mem_we_      = 1'b0;
    mem_vptr_    = 32'h0;
    mem_sw_data_ = 32'h0;
    if (grant_a) begin
      mem_we_      = _a_we;
      mem_vptr_    = _a_vptr;
      mem_sw_data_ = _a_sw_data;
    end else if (grant_b) begin
      mem_we_      = _b_we;
      mem_vptr_    = _b_vptr;
      mem_sw_data_ = _b_sw_data;
    end
  end

  assign a_gnt_       = grant_a;
  assign b_gnt_       = grant_b;
  assign a_rsp_valid_ = rsp_valid_a;
  assign b_rsp_valid_ = rsp_valid_b;
  assign a_lw_data_   = rsp_data_a;
  assign b_lw_data_   = rsp_data_b;

  always_ff @(posedge _clk or posedge _reset) begin
    if (_reset) begin
      owner       <= OWN_A;
      burst_cnt   <= 4'd0;
      rsp_valid_a <= 1'b0;
      rsp_valid_b <= 1'b0;
      rsp_data_a  <= 32'h0;
      rsp_data_b  <= 32'h0;
    end else begin
      if (grant_a || grant_b) begin
        // The winner always ends up as owner; only the counter differs.
        if ((grant_a && owner == OWN_A) || (grant_b && owner == OWN_B)) begin
          burst_cnt <= (burst_cnt == 4'hF) ? 4'hF : burst_cnt + 4'd1;
        end else begin
          burst_cnt <= 4'd1;
        end
        owner <= grant_b ? OWN_B : OWN_A;
      end else begin
        burst_cnt <= 4'd0;
      end

      rsp_valid_a <= grant_a && !_a_we;
      rsp_valid_b <= grant_b && !_b_we;
      if (grant_a && !_a_we) rsp_data_a <= _mem_lw_data;
      if (grant_b && !_b_we) rsp_data_b <= _mem_lw_data;
    end
  end

endmodule
